// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the instruction-fetch
// port and the data port. The data port wins ties. Each access runs over a
// variable-latency req/ack bus, and a wait counter turns a missing ack into a
// sticky bus error. Stalls hold each requester until its valid pulse.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    // instruction fetch port (read only)
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_valid,
    output logic          i_stall,
    // data port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          d_stall,
    // memory side
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, D_ACC, I_ACC, ERR} state_t;

    // The counter runs from 0, so the last cycle without an ack is cycle TIMEOUT.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt;
    logic       grant_d, grant_i, done, tmo;

    // State register. A reset abandons any outstanding access.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Arbitration and access sequencing. An ack in the final wait cycle beats the timeout.
    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_i   = 1'b0;
        done      = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE: begin
                if (d_req) begin
                    state_nxt = D_ACC;
                    grant_d   = 1'b1;
                end else if (i_req) begin
                    state_nxt = I_ACC;
                    grant_i   = 1'b1;
                end
            end
            D_ACC, I_ACC: begin
                if (m_ack) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ERR;
                    tmo       = 1'b1;
                end
            end
            ERR:     state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory bus, return data, valid pulses, wait counter and error flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            i_valid  <= 1'b0;
            d_valid  <= 1'b0;
            err      <= 1'b0;
            wait_cnt <= '0;
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            if (grant_d) begin
                m_req    <= 1'b1;
                m_we     <= d_we;
                m_addr   <= d_addr;
                m_wdata  <= d_wdata;
                wait_cnt <= '0;
            end else if (grant_i) begin
                // A fetch never drives write data onto the bus.
                m_req    <= 1'b1;
                m_we     <= 1'b0;
                m_addr   <= i_addr;
                m_wdata  <= '0;
                wait_cnt <= '0;
            end else if (done) begin
                m_req <= 1'b0;
                if (state == D_ACC) begin
                    d_valid <= 1'b1;
                    // A store leaves the last load result in place.
                    if (!m_we) d_rdata <= m_rdata;
                end else begin
                    i_valid <= 1'b1;
                    i_rdata <= m_rdata;
                end
            end else if (tmo) begin
                m_req <= 1'b0;
                err   <= 1'b1;
            end else if (m_req) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    // A port stalls while its request is pending, and both ports stall once the bus has failed.
    assign i_stall = err | (i_req & ~i_valid);
    assign d_stall = err | (d_req & ~d_valid);

endmodule
